// File: rtl/wdog_pkg.sv
// wdog_pkg: shared types and helpers for watchdog_timer.
//   wdog_state_t : supervisor FSM encoding (IDLE=0, RUN=1, EXPIRED=2, DONE=3)
//   fid_width()  : width of the first_id port for a given channel count
//   lowest_set() : index of the lowest set bit of a 32-bit vector (0 if none)
package wdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2,
        DONE    = 2'd3
    } wdog_state_t;

    function automatic int fid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lowest_set(input logic [31:0] v);
        int idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wdog_channel.sv
// wdog_channel: one supervised heartbeat channel -- saturating silence counter
// plus a sticky expiry flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_run       : count this cycle (supervisor in RUN/EXPIRED, no clear pending)
//   i_clr       : synchronously zero the counter and the expiry flag
//   i_en        : channel supervision enable (low holds the counter at 0)
//   i_kick      : heartbeat, restarts the silence count
//   o_hit       : this edge moves the counter TIMEOUT-1 -> TIMEOUT (new expiry)
//   o_expired   : sticky expiry flag
module wdog_channel #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_kick,
    output logic o_hit,
    output logic o_expired
);

    localparam logic [CW-1:0] TO   = CW'(TIMEOUT);
    localparam logic [CW-1:0] TOM1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_exp;

    // a kick on the timeout edge restarts the count instead of expiring
    assign o_hit     = i_run && i_en && !i_kick && (r_cnt == TOM1);
    assign o_expired = r_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_exp <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_exp <= 1'b0;
        end else if (i_run) begin
            r_cnt <= (i_kick || !i_en) ? '0 : (r_cnt == TO) ? r_cnt : r_cnt + CW'(1);
            if (o_hit) r_exp <= 1'b1;
        end
    end

endmodule

// File: rtl/watchdog_timer.sv
// watchdog_timer: multi-channel simulation watchdog and run-length limiter.
// Supervises NCH heartbeat channels, flags any channel silent for TIMEOUT
// cycles and raises done after MAX_CYCLES RUN/EXPIRED cycles.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_enable       : start/continue supervision
//   i_ch_en[NCH]   : per-channel supervision enable
//   i_kick[NCH]    : per-channel heartbeat
//   i_clear        : acknowledge expiry and resume supervision
//   o_expired[NCH] : sticky per-channel timeout flags
//   o_any_expired  : OR of o_expired
//   o_first_id     : lowest channel of the expiry event that entered EXPIRED
//   o_cycles[32]   : global run counter
//   o_done         : run length reached (sticky until reset)
//   o_state[2]     : current FSM state (wdog_state_t)
// Build option WDOG_FINISH_EN: report and end the simulation after DONE.
module watchdog_timer
    import wdog_pkg::*;
#(
    parameter int     NCH        = 4,
    parameter int     CW         = 16,
    parameter int     TIMEOUT    = 1000,
    parameter longint MAX_CYCLES = 10000,
    localparam int    FW         = fid_width(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_enable,
    input  logic [NCH-1:0] i_ch_en,
    input  logic [NCH-1:0] i_kick,
    input  logic           i_clear,
    output logic [NCH-1:0] o_expired,
    output logic           o_any_expired,
    output logic [FW-1:0]  o_first_id,
    output logic [31:0]    o_cycles,
    output logic           o_done,
    output logic [1:0]     o_state
);

    if (NCH < 1 || NCH > 32 || TIMEOUT < 2 || (CW < 31 && TIMEOUT >= (1 << CW)) ||
        MAX_CYCLES < 1 || MAX_CYCLES > 64'hFFFF_FFFF) begin : g_bad_param
        $error("watchdog_timer: illegal parameter combination");
    end

    wdog_state_t    r_state, w_next;
    logic [31:0]    r_cycles;
    logic [FW-1:0]  r_fid;
    logic [NCH-1:0] w_hit, w_exp;
    logic           w_act, w_last, w_clr, w_run;

    assign w_act  = (r_state == RUN) || (r_state == EXPIRED);
    assign w_last = w_act && (r_cycles == 32'(MAX_CYCLES - 1));
    // reaching the run length overrides both disable and clear on that edge
    assign w_clr  = (r_state == IDLE) ||
                    (!w_last && (((r_state == RUN) && !i_enable) || ((r_state == EXPIRED) && i_clear)));
    assign w_run  = w_act && !w_clr;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        wdog_channel #(.CW(CW), .TIMEOUT(TIMEOUT)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_run     (w_run),
            .i_clr     (w_clr),
            .i_en      (i_ch_en[g]),
            .i_kick    (i_kick[g]),
            .o_hit     (w_hit[g]),
            .o_expired (w_exp[g])
        );
    end

    always_comb begin
        w_next = r_state;
        if (w_last)                              w_next = DONE;
        else if (r_state == IDLE && i_enable)    w_next = RUN;
        else if (r_state == RUN && !i_enable)    w_next = IDLE;
        else if (r_state == RUN && |w_hit)       w_next = EXPIRED;
        else if (r_state == EXPIRED && i_clear)  w_next = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cycles <= '0;
            r_fid    <= '0;
        end else begin
            r_state <= w_next;
            if (w_act) r_cycles <= r_cycles + 32'd1;
            if (r_state == EXPIRED && i_clear && !w_last) r_fid <= '0;
            else if (r_state == RUN && w_next == EXPIRED) r_fid <= FW'(lowest_set(32'(w_hit)));
        end
    end

    assign o_expired     = w_exp;
    assign o_any_expired = |w_exp;
    assign o_first_id    = r_fid;
    assign o_cycles      = r_cycles;
    assign o_done        = (r_state == DONE);
    assign o_state       = r_state;

`ifdef WDOG_FINISH_EN
    logic r_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fin <= 1'b0;
        end else if (w_last) begin
            $display("watchdog_timer: run complete cycles=%0d expired=%b first_id=%0d",
                     MAX_CYCLES, w_exp | w_hit, r_fid);
            r_fin <= 1'b1;
        end else if (r_fin) begin
            if (o_any_expired) $error("watchdog_timer: channel timeout, expired=%b", w_exp);
            $finish;
        end
    end
`else
    // no system tasks: the instantiating top watches o_done and owns termination
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
module tb_watchdog_timer;

    localparam int     NCH  = 4;
    localparam int     CW   = 8;
    localparam int     TO   = 8;
    localparam longint MAXC = 400;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           clear = 1'b0;
    logic [NCH-1:0] ch_en = '1;
    logic [NCH-1:0] kick = '0;
    logic [NCH-1:0] expired;
    logic           any_expired;
    logic [1:0]     first_id;
    logic [31:0]    cycles;
    logic           done;
    logic [1:0]     state;

    int checks = 0;
    int failures = 0;

    // reference model: state as 0=IDLE 1=RUN 2=EXPIRED 3=DONE, silence ages per channel
    int             m_state, m_cycles, m_fid;
    int             m_age[NCH];
    logic [NCH-1:0] m_exp;

    always #5 clk = ~clk;

    watchdog_timer #(.NCH(NCH), .CW(CW), .TIMEOUT(TO), .MAX_CYCLES(MAXC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_ch_en       (ch_en),
        .i_kick        (kick),
        .i_clear       (clear),
        .o_expired     (expired),
        .o_any_expired (any_expired),
        .o_first_id    (first_id),
        .o_cycles      (cycles),
        .o_done        (done),
        .o_state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("any_expired", 32'(any_expired), 32'(m_exp != 0));
        chk("first_id", 32'(first_id), 32'(m_fid));
        chk("cycles", cycles, 32'(m_cycles));
        chk("done", 32'(done), 32'(m_state == 3));
    endtask

    task automatic model_reset();
        m_state = 0; m_cycles = 0; m_fid = 0; m_exp = '0;
        for (int i = 0; i < NCH; i++) m_age[i] = 0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] nh = '0;
        bit last;
        if (m_state == 0) begin
            if (enable) m_state = 1;
        end else if (m_state != 3) begin
            last = (m_cycles == MAXC - 1);
            m_cycles++;
            if (!last && m_state == 1 && !enable) begin
                m_state = 0;
                for (int i = 0; i < NCH; i++) m_age[i] = 0;
            end else if (!last && m_state == 2 && clear) begin
                m_state = 1; m_exp = '0; m_fid = 0;
                for (int i = 0; i < NCH; i++) m_age[i] = 0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (kick[i] || !ch_en[i]) m_age[i] = 0;
                    else begin
                        if (m_age[i] == TO - 1) nh[i] = 1'b1;
                        if (m_age[i] < TO) m_age[i]++;
                    end
                end
                m_exp |= nh;
                if (last) m_state = 3;
                else if (m_state == 1 && nh != 0) begin
                    m_state = 2;
                    for (int i = NCH - 1; i >= 0; i--) if (nh[i]) m_fid = i;
                end
            end
        end
    endtask

    task automatic cyc(input logic e, input logic [NCH-1:0] ce, input logic [NCH-1:0] k, input logic c);
        enable = e; ch_en = ce; kick = k; clear = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [NCH-1:0] rand_kick();
        logic [NCH-1:0] k;
        for (int i = 0; i < NCH; i++) k[i] = ($urandom % 6) == 0;
        return k;
    endfunction

    initial begin
        int saved;
        model_reset();
        #2;
        check_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // steady kicking every 4 cycles never expires
        cyc(1, '1, '0, 0);
        for (int k = 0; k < 100; k++) cyc(1, '1, (k % 4 == 0) ? 4'hf : 4'h0, 0);
        chk("steady_state", 32'(state), 32'd1);
        chk("steady_expired", 32'(expired), 32'd0);

        // channel 2 silent after one kick: expires exactly TIMEOUT edges later
        cyc(1, '1, 4'hf, 0);
        repeat (TO) cyc(1, '1, 4'hb, 0);
        chk("ch2_expired", 32'(expired), 32'h4);
        chk("ch2_first_id", 32'(first_id), 32'd2);
        chk("ch2_state", 32'(state), 32'd2);
        repeat (2) cyc(1, '1, 4'hf, 0);
        cyc(1, '1, 4'hf, 1);
        chk("clear_expired", 32'(expired), 32'd0);
        chk("clear_state", 32'(state), 32'd1);

        // channels 1 and 3 expire together; ch0 kicked on its timeout edge
        cyc(1, '1, 4'hf, 0);
        repeat (TO - 1) cyc(1, '1, 4'h4, 0);
        cyc(1, '1, 4'h5, 0);
        chk("dual_expired", 32'(expired), 32'ha);
        chk("dual_first_id", 32'(first_id), 32'd1);
        cyc(1, '1, '1, 1);

        // disabled channel never expires
        repeat (50) cyc(1, 4'he, 4'he, 0);
        chk("ch_en0_expired", 32'(expired), 32'd0);

        // drop enable: IDLE, cycles frozen, counters restart from zero
        cyc(0, '1, '1, 0);
        saved = m_cycles;
        repeat (5) cyc(0, '1, '0, 0);
        chk("idle_frozen", cycles, 32'(saved));
        cyc(1, '1, '0, 0);
        repeat (TO - 1) cyc(1, '1, '0, 0);
        chk("restart_no_exp", 32'(expired), 32'd0);
        cyc(1, '1, '0, 0);
        chk("restart_exp", 32'(expired), 32'hf);
        chk("restart_fid", 32'(first_id), 32'd0);
        cyc(1, '1, '1, 1);

        // randomized traffic until the run length is reached
        for (int n = 0; n < 2000 && m_state != 3; n++)
            cyc(($urandom % 25) != 0, (($urandom % 8) == 0) ? 4'($urandom) : 4'hf,
                rand_kick(), ($urandom % 4) == 0);
        chk("reached_done", 32'(state), 32'd3);
        chk("done_cycles", cycles, 32'(MAXC));
        repeat (5) cyc(1, '1, rand_kick(), ($urandom % 2) == 0);

        // asynchronous reset while EXPIRED with only channel 0 expired
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, '1, '1, 0);
        repeat (TO) cyc(1, '1, 4'he, 0);
        chk("pre_rst_expired", 32'(expired), 32'h1);
        chk("pre_rst_state", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #10;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
